rans_freq_table: RTL and testbench
==================================

// Module: rans_freq_table
// PURPOSE
// Upstream stage of the rANS encoder: holds the per-symbol frequency table and derives cumulative
// frequencies by an internal prefix-sum pass. Checks the table total, then serves lookups:
// symbol in, {symb, freq, cum_freq} out, one cycle later. Outputs feed the encoder's
// symb_i/freq_i/cum_freq_i/en_i; its ready_o returns here as ready_i.
// PARAMETERS
// RESOLUTION    10                   log2 of probability scale M; table total must equal 2**RESOLUTION
// SYMBOL_WIDTH  8                    symbol width in bits
// NUM_SYMBOLS   2**SYMBOL_WIDTH      table depth; entries indexed 0..NUM_SYMBOLS-1
// PORTS
// clk_i         in   1             single clock, all logic rising-edge
// rst_i         in   1             asynchronous, active-high reset
// load_start_i  in   1             pulse: abort any activity, start CLEAR then LOAD
// load_valid_i  in   1             frequency write strobe (LOAD only)
// load_symb_i   in   SYMBOL_WIDTH  symbol being written
// load_freq_i   in   RESOLUTION    its frequency
// load_done_i   in   1             pulse: table complete, start SCAN
// load_ready_o  out  1             1 only in LOAD
// symb_valid_i  in   1             lookup request
// symb_i        in   SYMBOL_WIDTH  symbol to look up
// symb_ready_o  out  1             lookup accepted when symb_valid_i & symb_ready_o
// valid_o       out  1             lookup result valid (drives encoder en_i)
// ready_i       in   1             encoder ready_o
// symb_o        out  SYMBOL_WIDTH  looked-up symbol
// freq_o        out  RESOLUTION    its frequency
// cum_freq_o    out  RESOLUTION    sum of freq of all lower-indexed symbols
// table_ok_o    out  1             1 while in READY
// table_err_o   out  1             1 while in ERROR (total != 2**RESOLUTION)
// zero_err_o    out  1             sticky: a lookup hit a zero-frequency symbol
// BEHAVIOUR
// - Reset: state EMPTY; all outputs 0; address counter 0; accumulator 0. Table RAMs not reset.
// - FSM: EMPTY -load_start_i-> CLEAR -NUM_SYMBOLS cycles-> LOAD -load_done_i-> SCAN -NUM_SYMBOLS cycles-> READY|ERROR.
// - CLEAR: addr counter walks 0..NUM_SYMBOLS-1, one freq entry zeroed per cycle; load_ready_o=0.
// - LOAD: each load_valid_i writes freq[load_symb_i]; duplicate symbol = last write wins.
//   load_valid_i and load_done_i in same cycle: write performed, then SCAN.
// - SCAN: per cycle i: cum[i] <= acc; acc <= acc + freq[i]; acc is RESOLUTION+1 bits, saturating
//   at 2**(RESOLUTION+1)-1 (no wrap). After last entry: acc == 2**RESOLUTION -> READY, else ERROR.
// - load_start_i in any state (incl. READY/ERROR/SCAN) -> CLEAR next cycle; valid_o cleared;
//   zero_err_o cleared. load_valid_i/load_done_i outside LOAD ignored.
// - READY: symb_ready_o = !valid_o | ready_i. On accept, next cycle valid_o=1 with
//   symb_o=symb_i, freq_o=freq[symb_i], cum_freq_o=cum[symb_i] (latency 1). Accept and
//   ready_i same cycle: back-to-back, 1 result/cycle. valid_o & !ready_i: outputs held stable.
// - Zero-frequency symbol: not forwarded (valid_o stays/goes 0 for that slot); zero_err_o set
//   (sticky until reset or load_start_i).
// - ERROR/EMPTY/CLEAR/LOAD/SCAN: symb_ready_o=0, valid_o=0.
// - Single symbol with freq 2**RESOLUTION is not representable (freq max 2**RESOLUTION-1) -> ERROR.
// - Reset mid-operation: immediate return to EMPTY, outputs 0; table must be reloaded.
// TESTING
// 1 load 0x61=512,0x62=256,0x63=256, done -> after 256 SCAN cycles table_ok_o=1; lookup 0x62
//   -> next cycle valid_o=1, freq_o=256, cum_freq_o=512; lookup 0x61 -> cum_freq_o=0.
// 2 load 0x00=500,0x01=500 (total 1000), done -> table_err_o=1, symb_ready_o=0; 1023+1023 -> ERROR.
// 3 READY, ready_i=0 for 5 cycles with pending result -> outputs stable, symb_ready_o=0;
//   then ready_i=1 with streaming symbols -> one result per cycle, order preserved.
// 4 lookup 0x7f (freq 0) -> no valid_o for it, zero_err_o=1 and stays 1; next valid lookup OK.
// 5 load_start_i mid-SCAN -> CLEAR, load_ready_o=1 after NUM_SYMBOLS cycles; prior freqs read 0.
// 6 rst_i asserted mid-LOAD -> all outputs 0 async; load_valid_i ignored until load_start_i.

Source files
------------

// File: rtl/rans_freq_table_if.sv
// Load and lookup handshake bundle between the rANS frequency table and its neighbours.
// The DUT takes the slave modport; the table loader and lookup requester drive the master side.
interface rans_freq_table_if #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int RESOLUTION   = 10
);
  logic                    load_start_i;
  logic                    load_valid_i;
  logic [SYMBOL_WIDTH-1:0] load_symb_i;
  logic [RESOLUTION-1:0]   load_freq_i;
  logic                    load_done_i;
  logic                    load_ready_o;
  logic                    symb_valid_i;
  logic [SYMBOL_WIDTH-1:0] symb_i;
  logic                    symb_ready_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [SYMBOL_WIDTH-1:0] symb_o;
  logic [RESOLUTION-1:0]   freq_o;
  logic [RESOLUTION-1:0]   cum_freq_o;
  logic                    table_ok_o;
  logic                    table_err_o;
  logic                    zero_err_o;

  modport master (
    output load_start_i, load_valid_i, load_symb_i, load_freq_i, load_done_i,
    output symb_valid_i, symb_i, ready_i,
    input  load_ready_o, symb_ready_o, valid_o, symb_o, freq_o, cum_freq_o,
    input  table_ok_o, table_err_o, zero_err_o
  );

  modport slave (
    input  load_start_i, load_valid_i, load_symb_i, load_freq_i, load_done_i,
    input  symb_valid_i, symb_i, ready_i,
    output load_ready_o, symb_ready_o, valid_o, symb_o, freq_o, cum_freq_o,
    output table_ok_o, table_err_o, zero_err_o
  );
endinterface

// File: rtl/rans_freq_table.sv
// rANS symbol frequency table: clear, load, prefix-sum scan with total check, then
// one-cycle-latency {symb, freq, cum_freq} lookups toward the encoder.
module rans_freq_table #(
  parameter int RESOLUTION   = 10,
  parameter int SYMBOL_WIDTH = 8,
  parameter int NUM_SYMBOLS  = 2**SYMBOL_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rans_freq_table_if.slave bus
);

  typedef enum logic [2:0] {EMPTY, CLEAR, LOAD, SCAN, READY, ERROR} state_t;

  localparam logic [SYMBOL_WIDTH-1:0] LAST_ADDR = SYMBOL_WIDTH'(NUM_SYMBOLS - 1);
  localparam logic [RESOLUTION:0]     TOTAL     = {1'b1, {RESOLUTION{1'b0}}};

  // Accumulator add that pins at all-ones instead of wrapping, so a grossly
  // oversized table can never alias back onto the exact total.
  function automatic logic [RESOLUTION:0] sat_add(input logic [RESOLUTION:0]   a,
                                                  input logic [RESOLUTION-1:0] b);
    logic [RESOLUTION+1:0] s;
    s = {1'b0, a} + {2'b00, b};
    if (s[RESOLUTION+1]) return '1;
    return s[RESOLUTION:0];
  endfunction

  state_t                  state, state_nxt;
  logic [SYMBOL_WIDTH-1:0] addr;
  logic [RESOLUTION:0]     acc;
  logic [RESOLUTION:0]     scan_total;
  logic [RESOLUTION-1:0]   freq_mem [NUM_SYMBOLS];
  logic [RESOLUTION-1:0]   cum_mem  [NUM_SYMBOLS];
  logic [SYMBOL_WIDTH-1:0] rd_addr;
  logic [RESOLUTION-1:0]   rd_freq;
  logic [RESOLUTION-1:0]   rd_cum;
  logic                    mem_we;
  logic [SYMBOL_WIDTH-1:0] mem_waddr;
  logic [RESOLUTION-1:0]   mem_wdata;
  logic                    accept;
  logic                    vld_p1;
  logic [SYMBOL_WIDTH-1:0] symb_p1;
  logic [RESOLUTION-1:0]   freq_p1;
  logic [RESOLUTION-1:0]   cum_p1;
  logic                    zero_err;

  assign rd_addr    = (state == SCAN) ? addr : bus.symb_i;
  assign rd_freq    = freq_mem[rd_addr];
  assign rd_cum     = cum_mem[bus.symb_i];
  assign scan_total = sat_add(acc, rd_freq);

  assign mem_we    = (state == CLEAR) || ((state == LOAD) && bus.load_valid_i);
  assign mem_waddr = (state == CLEAR) ? addr : bus.load_symb_i;
  assign mem_wdata = (state == CLEAR) ? '0 : bus.load_freq_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) freq_mem[mem_waddr] <= mem_wdata;
    if (state == SCAN) cum_mem[addr] <= acc[RESOLUTION-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.load_start_i) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        CLEAR:   if (addr == LAST_ADDR) state_nxt = LOAD;
        LOAD:    if (bus.load_done_i) state_nxt = SCAN;
        SCAN:    if (addr == LAST_ADDR) state_nxt = (scan_total == TOTAL) ? READY : ERROR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr <= '0;
      acc  <= '0;
    end else if (bus.load_start_i) begin
      addr <= '0;
      acc  <= '0;
    end else begin
      case (state)
        CLEAR: addr <= addr + 1'b1;
        LOAD: begin
          if (bus.load_done_i) begin
            addr <= '0;
            acc  <= '0;
          end
        end
        SCAN: begin
          addr <= addr + 1'b1;
          acc  <= scan_total;
        end
        default: ;
      endcase
    end
  end

  assign accept = bus.symb_valid_i && bus.symb_ready_o;

  // Stage p1: registered lookup result, held while the encoder stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      symb_p1  <= '0;
      freq_p1  <= '0;
      cum_p1   <= '0;
      zero_err <= 1'b0;
    end else if (bus.load_start_i) begin
      vld_p1   <= 1'b0;
      zero_err <= 1'b0;
    end else if (state == READY) begin
      if (accept) begin
        if (rd_freq == '0) begin
          vld_p1   <= 1'b0;
          zero_err <= 1'b1;
        end else begin
          vld_p1  <= 1'b1;
          symb_p1 <= bus.symb_i;
          freq_p1 <= rd_freq;
          cum_p1  <= rd_cum;
        end
      end else if (bus.ready_i) begin
        vld_p1 <= 1'b0;
      end
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.load_ready_o = (state == LOAD);
  assign bus.symb_ready_o = (state == READY) && (!vld_p1 || bus.ready_i);
  assign bus.valid_o      = vld_p1;
  assign bus.symb_o       = symb_p1;
  assign bus.freq_o       = freq_p1;
  assign bus.cum_freq_o   = cum_p1;
  assign bus.table_ok_o   = (state == READY);
  assign bus.table_err_o  = (state == ERROR);
  assign bus.zero_err_o   = zero_err;

endmodule

// File: tb/tb_rans_freq_table.sv
// Directed bench for rans_freq_table: load/scan outcomes, lookups, stalls, zero-frequency
// handling, restart during scan and asynchronous reset during load.
module tb_rans_freq_table;

  localparam int SW  = 8;
  localparam int RES = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rans_freq_table_if #(.SYMBOL_WIDTH(SW), .RESOLUTION(RES)) bus ();

  rans_freq_table #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start_i = 1'b0;
    bus.load_valid_i = 1'b0;
    bus.load_symb_i  = '0;
    bus.load_freq_i  = '0;
    bus.load_done_i  = 1'b0;
    bus.symb_valid_i = 1'b0;
    bus.symb_i       = '0;
    bus.ready_i      = 1'b1;
  endtask

  // Pulse load_start and wait (bounded) for LOAD; returns number of CLEAR cycles
  task automatic start_load(output int n);
    bus.load_start_i = 1'b1;
    tick();
    bus.load_start_i = 1'b0;
    n = 0;
    while (!bus.load_ready_o && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic write_freq(input logic [SW-1:0] s, input logic [RES-1:0] f, input logic done);
    bus.load_valid_i = 1'b1;
    bus.load_symb_i  = s;
    bus.load_freq_i  = f;
    bus.load_done_i  = done;
    tick();
    bus.load_valid_i = 1'b0;
    bus.load_done_i  = 1'b0;
  endtask

  // Pulse load_done and wait (bounded) for the scan outcome; returns scan cycles
  task automatic finish_scan(input logic send_done, output int n);
    if (send_done) begin
      bus.load_done_i = 1'b1;
      tick();
      bus.load_done_i = 1'b0;
    end
    n = 0;
    while (!(bus.table_ok_o || bus.table_err_o) && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.load_ready_o, bus.symb_ready_o, bus.valid_o, bus.table_ok_o,
         bus.table_err_o, bus.zero_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {bus.load_ready_o, bus.symb_ready_o,
               bus.valid_o, bus.table_ok_o, bus.table_err_o, bus.zero_err_o});
    end
    checks++;
    if ({bus.symb_o, bus.freq_o, bus.cum_freq_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got symb=%0d freq=%0d cum=%0d expected 0", bus.symb_o,
               bus.freq_o, bus.cum_freq_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic load_table1();
    int n;
    start_load(n);
    write_freq(8'h61, 10'd100, 1'b0);
    write_freq(8'h61, 10'd512, 1'b0);
    write_freq(8'h62, 10'd256, 1'b0);
    write_freq(8'h63, 10'd256, 1'b1);
    finish_scan(1'b0, n);
  endtask

  task automatic test_basic_lookup();
    int n;
    start_load(n);
    checks++;
    if (n !== 256 || bus.load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL clear_cycles: got %0d ready=%b expected 256 ready=1", n, bus.load_ready_o);
    end
    write_freq(8'h61, 10'd100, 1'b0);
    write_freq(8'h61, 10'd512, 1'b0);
    write_freq(8'h62, 10'd256, 1'b0);
    write_freq(8'h63, 10'd256, 1'b1);
    finish_scan(1'b0, n);
    checks++;
    if (n !== 256 || bus.table_ok_o !== 1'b1 || bus.table_err_o !== 1'b0) begin
      errors++;
      $display("FAIL scan_ok: got cycles=%0d ok=%b err=%b expected 256 ok=1 err=0", n,
               bus.table_ok_o, bus.table_err_o);
    end
    bus.ready_i      = 1'b1;
    bus.symb_valid_i = 1'b1;
    bus.symb_i       = 8'h62;
    checks++;
    if (bus.symb_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL symb_ready_idle: got %b expected 1", bus.symb_ready_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.symb_o !== 8'h62 || bus.freq_o !== 10'd256 ||
        bus.cum_freq_o !== 10'd512) begin
      errors++;
      $display("FAIL lookup_62: got v=%b s=%h f=%0d c=%0d expected v=1 s=62 f=256 c=512",
               bus.valid_o, bus.symb_o, bus.freq_o, bus.cum_freq_o);
    end
    bus.symb_i = 8'h61;
    tick();
    bus.symb_valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.symb_o !== 8'h61 || bus.freq_o !== 10'd512 ||
        bus.cum_freq_o !== 10'd0) begin
      errors++;
      $display("FAIL lookup_61: got v=%b s=%h f=%0d c=%0d expected v=1 s=61 f=512 c=0",
               bus.valid_o, bus.symb_o, bus.freq_o, bus.cum_freq_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL lookup_drain: got valid=%b expected 0", bus.valid_o);
    end
  endtask

  task automatic test_bad_totals();
    int n;
    logic [SW-1:0]  bs [3];
    logic [RES-1:0] bf [3];
    start_load(n);
    write_freq(8'h00, 10'd500, 1'b0);
    write_freq(8'h01, 10'd500, 1'b0);
    finish_scan(1'b1, n);
    bus.symb_valid_i = 1'b1;
    bus.symb_i       = 8'h00;
    #1;
    checks++;
    if (bus.table_err_o !== 1'b1 || bus.table_ok_o !== 1'b0 || bus.symb_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL total_1000: got err=%b ok=%b rdy=%b expected err=1 ok=0 rdy=0",
               bus.table_err_o, bus.table_ok_o, bus.symb_ready_o);
    end
    tick();
    bus.symb_valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL error_no_valid: got %b expected 0", bus.valid_o);
    end
    start_load(n);
    write_freq(8'h00, 10'd1023, 1'b0);
    write_freq(8'h01, 10'd1023, 1'b0);
    finish_scan(1'b1, n);
    checks++;
    if (bus.table_err_o !== 1'b1) begin
      errors++;
      $display("FAIL total_2046: got err=%b expected 1", bus.table_err_o);
    end
    // 3*1023+3 = 3072 would wrap to exactly 1024 without saturation
    bs = '{8'h10, 8'h11, 8'h12};
    bf = '{10'd1023, 10'd1023, 10'd1023};
    start_load(n);
    for (int i = 0; i < 3; i++) write_freq(bs[i], bf[i], 1'b0);
    write_freq(8'h13, 10'd3, 1'b1);
    finish_scan(1'b0, n);
    checks++;
    if (bus.table_err_o !== 1'b1 || bus.table_ok_o !== 1'b0) begin
      errors++;
      $display("FAIL total_saturate: got err=%b ok=%b expected err=1 ok=0",
               bus.table_err_o, bus.table_ok_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0]  es [3];
    logic [RES-1:0] ef [3];
    logic [RES-1:0] ec [3];
    load_table1();
    bus.ready_i      = 1'b0;
    bus.symb_valid_i = 1'b1;
    bus.symb_i       = 8'h61;
    tick();
    bus.symb_i = 8'h63;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.valid_o !== 1'b1 || bus.symb_o !== 8'h61 || bus.freq_o !== 10'd512 ||
          bus.cum_freq_o !== 10'd0 || bus.symb_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b s=%h f=%0d c=%0d rdy=%b expected v=1 s=61 f=512 c=0 rdy=0",
                 i, bus.valid_o, bus.symb_o, bus.freq_o, bus.cum_freq_o, bus.symb_ready_o);
      end
      tick();
    end
    es = '{8'h62, 8'h63, 8'h61};
    ef = '{10'd256, 10'd256, 10'd512};
    ec = '{10'd512, 10'd768, 10'd0};
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.symb_i = es[i];
      tick();
      checks++;
      if (bus.valid_o !== 1'b1 || bus.symb_o !== es[i] || bus.freq_o !== ef[i] ||
          bus.cum_freq_o !== ec[i]) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b s=%h f=%0d c=%0d expected v=1 s=%h f=%0d c=%0d",
                 i, bus.valid_o, bus.symb_o, bus.freq_o, bus.cum_freq_o, es[i], ef[i], ec[i]);
      end
    end
    bus.symb_valid_i = 1'b0;
    tick();
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got valid=%b expected 0", bus.valid_o);
    end
  endtask

  task automatic test_zero_freq();
    bus.ready_i      = 1'b1;
    bus.symb_valid_i = 1'b1;
    bus.symb_i       = 8'h7f;
    tick();
    bus.symb_valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.zero_err_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_lookup: got v=%b zerr=%b expected v=0 zerr=1", bus.valid_o,
               bus.zero_err_o);
    end
    tick();
    tick();
    bus.symb_valid_i = 1'b1;
    bus.symb_i       = 8'h62;
    tick();
    bus.symb_valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.freq_o !== 10'd256 || bus.cum_freq_o !== 10'd512 ||
        bus.zero_err_o !== 1'b1) begin
      errors++;
      $display("FAIL zero_then_ok: got v=%b f=%0d c=%0d zerr=%b expected v=1 f=256 c=512 zerr=1",
               bus.valid_o, bus.freq_o, bus.cum_freq_o, bus.zero_err_o);
    end
    tick();
  endtask

  task automatic test_restart_mid_scan();
    int n;
    start_load(n);
    checks++;
    if (bus.zero_err_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_err_clear: got %b expected 0", bus.zero_err_o);
    end
    write_freq(8'h61, 10'd512, 1'b0);
    write_freq(8'h62, 10'd256, 1'b1);
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (bus.table_ok_o !== 1'b0 || bus.table_err_o !== 1'b0 || bus.load_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_scan: got ok=%b err=%b lrdy=%b expected 000", bus.table_ok_o,
               bus.table_err_o, bus.load_ready_o);
    end
    start_load(n);
    checks++;
    if (n !== 256 || bus.load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: got %0d ready=%b expected 256 ready=1", n, bus.load_ready_o);
    end
    write_freq(8'h00, 10'd1023, 1'b0);
    write_freq(8'h01, 10'd1, 1'b1);
    finish_scan(1'b0, n);
    checks++;
    if (bus.table_ok_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_total: got ok=%b err=%b expected ok=1", bus.table_ok_o,
               bus.table_err_o);
    end
    bus.symb_valid_i = 1'b1;
    bus.symb_i       = 8'h61;
    tick();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.zero_err_o !== 1'b1) begin
      errors++;
      $display("FAIL cleared_entry: got v=%b zerr=%b expected v=0 zerr=1", bus.valid_o,
               bus.zero_err_o);
    end
    bus.symb_i = 8'h01;
    tick();
    bus.symb_valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.freq_o !== 10'd1 || bus.cum_freq_o !== 10'd1023) begin
      errors++;
      $display("FAIL lookup_01: got v=%b f=%0d c=%0d expected v=1 f=1 c=1023", bus.valid_o,
               bus.freq_o, bus.cum_freq_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    int n;
    start_load(n);
    write_freq(8'h05, 10'd1000, 1'b0);
    bus.symb_valid_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.load_ready_o, bus.valid_o, bus.table_ok_o, bus.table_err_o, bus.zero_err_o,
         bus.symb_ready_o} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000000", {bus.load_ready_o, bus.valid_o,
               bus.table_ok_o, bus.table_err_o, bus.zero_err_o, bus.symb_ready_o});
    end
    bus.symb_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    write_freq(8'h05, 10'd24, 1'b1);
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (bus.load_ready_o !== 1'b0 || bus.table_ok_o !== 1'b0 || bus.table_err_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_after_reset: got lrdy=%b ok=%b err=%b expected 000",
               bus.load_ready_o, bus.table_ok_o, bus.table_err_o);
    end
    start_load(n);
    checks++;
    if (n !== 256 || bus.load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reload_after_reset: got %0d ready=%b expected 256 ready=1", n,
               bus.load_ready_o);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic_lookup();
    test_bad_totals();
    test_back_to_back();
    test_zero_freq();
    test_restart_mid_scan();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
